// File: rtl/seq_det_sched.sv
// Round-robin scheduler that shares one serial sequence detector among NREQ requesters.
// Each granted frame is streamed LSB-first after a one-cycle detector clear; hits are counted and returned.
module seq_det_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ),
  parameter int CW   = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] frame_data,
  output logic [NREQ-1:0]   ack,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [CW-1:0]     hit_cnt,
  output logic              busy,
  output logic              det_in,
  output logic              det_rst_n,
  input  logic              det_out
);

  // state | meaning
  // IDLE  | waiting for a request; grants and latches the winning frame
  // CLR   | detector held in reset for one cycle
  // SHIFT | W cycles streaming sh[0] into the detector, counting det_out
  // DONE  | one-cycle ack/done pulse, round-robin pointer advances
  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gid;
  logic [IDW-1:0] grant_id;
  logic           grant_vld;
  logic [W-1:0]   sh;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  bcnt;
  logic           last_bit;

  // Scan downward so the smallest offset from rr_ptr is the final (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NREQ]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  assign last_bit = (state == SHIFT) && (bcnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant_vld) state_nxt = CLR;
      CLR:   state_nxt = SHIFT;
      SHIFT: if (last_bit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign det_in = (state == SHIFT) & sh[0];
  assign done   = (state == DONE);
  assign ack    = done ? (NREQ'(1) << gid) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      gid       <= '0;
      sh        <= '0;
      cnt       <= '0;
      bcnt      <= '0;
      done_id   <= '0;
      hit_cnt   <= '0;
      det_rst_n <= 1'b0;
    end else begin
      // Registered so the detector reset is glitch-free and low exactly during CLR.
      det_rst_n <= (state_nxt != CLR);
      case (state)
        IDLE: begin
          if (grant_vld) begin
            sh   <= frame_data[grant_id*W +: W];
            gid  <= grant_id;
            cnt  <= '0;
            bcnt <= CW'(W - 1);
          end
        end
        SHIFT: begin
          sh   <= sh >> 1;
          bcnt <= bcnt - CW'(1);
          if (det_out) cnt <= cnt + CW'(1);
          // Result registers load on the last bit so they are valid throughout DONE and hold afterwards.
          if (bcnt == '0) begin
            done_id <= gid;
            hit_cnt <= cnt + CW'(det_out);
          end
        end
        DONE: rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with a behavioural detector flagging overlapping 1111 or 1001.
// Expected grant order, hit counts and cycle spacing are hand-computed per vector.
module tb_seq_det_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] frame_data = '0;
  logic [NREQ-1:0]   ack;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [CW-1:0]     hit_cnt;
  logic              busy;
  logic              det_in;
  logic              det_rst_n;
  logic              det_out;

  int errors = 0;
  int checks = 0;
  int last_lo;
  int last_bh;

  always #5 clk = ~clk;

  seq_det_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .frame_data(frame_data),
    .ack(ack), .done(done), .done_id(done_id), .hit_cnt(hit_cnt), .busy(busy),
    .det_in(det_in), .det_rst_n(det_rst_n), .det_out(det_out)
  );

  // Mealy detector: out when the last three bits plus det_in form 1111 or 1001.
  logic [2:0] hist;
  logic [1:0] vcnt;
  always_ff @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) begin
      hist <= '0;
      vcnt <= '0;
    end else begin
      hist <= {hist[1:0], det_in};
      if (vcnt != 2'd3) vcnt <= vcnt + 2'd1;
    end
  end
  assign det_out = (vcnt == 2'd3) &&
                   (({hist, det_in} == 4'b1111) || ({hist, det_in} == 4'b1001));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_frame(input int i, input logic [W-1:0] v);
    frame_data[i*W +: W] = v;
  endtask

  // Waits (bounded) for done; exp_cyc counts negedges from the call to the done cycle.
  task automatic serve(input string tag, input int exp_id, input int exp_hits, input int exp_cyc);
    int cyc, lo, bh;
    logic got;
    cyc = 0; lo = 0; bh = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!det_rst_n) lo++;
      if (busy) bh++;
      if (done) got = 1'b1;
    end
    check({tag, ".done"}, got, 1);
    check({tag, ".cyc"}, cyc, exp_cyc);
    check({tag, ".id"}, done_id, exp_id);
    check({tag, ".hits"}, hit_cnt, exp_hits);
    check({tag, ".ack"}, ack, 64'(1) << exp_id);
    last_lo = lo;
    last_bh = bh;
  endtask

  initial begin
    logic saw;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.ack", ack, 0);
    check("rst.done_id", done_id, 0);
    check("rst.hit_cnt", hit_cnt, 0);
    check("rst.det_rst_n", det_rst_n, 0);
    check("rst.det_in", det_in, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst.det_rst_n_rise", det_rst_n, 1);
    check("idle.busy", busy, 0);

    // single frame 0xFF
    set_frame(0, 8'hFF);
    req = 4'b0001;
    serve("t1", 0, 5, 10);
    check("t1.busy_cycles", last_bh, 10);
    check("t1.clr_cycles", last_lo, 1);
    req = '0;
    @(negedge clk);
    check("t1.idle_busy", busy, 0);
    check("t1.idle_done", done, 0);
    check("t1.hold_hits", hit_cnt, 5);
    check("t1.hold_id", done_id, 0);

    // 0x49 LSB-first 1,0,0,1,0,0,1,0
    set_frame(1, 8'h49);
    req = 4'b0010;
    serve("t2", 1, 2, 10);
    req = '0;
    @(negedge clk);

    // back-to-back frames, detector cleared between them
    set_frame(1, 8'hFF);
    req = 4'b0010;
    serve("t3a", 1, 5, 10);
    check("t3a.clr_cycles", last_lo, 1);
    set_frame(2, 8'hFF);
    req = 4'b0100;
    serve("t3b", 2, 5, 11);
    check("t3b.clr_cycles", last_lo, 1);
    req = '0;
    @(negedge clk);
    set_frame(0, 8'h00);
    req = 4'b0001;
    serve("t3c", 0, 0, 10);
    req = '0;
    @(negedge clk);

    // round-robin with held requests
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_frame(0, 8'hFF);
    set_frame(1, 8'h49);
    set_frame(2, 8'h00);
    set_frame(3, 8'h0F);
    req = 4'b0101;
    serve("t4a", 0, 5, 10);
    serve("t4b", 2, 0, 11);
    serve("t4c", 0, 5, 11);
    serve("t4d", 2, 0, 11);
    req = 4'b1111;
    serve("t4e", 3, 1, 11);
    serve("t4f", 0, 5, 11);
    serve("t4g", 1, 2, 11);
    serve("t4h", 2, 0, 11);
    req = '0;
    @(negedge clk);

    // reset mid-SHIFT (rr_ptr was 3), frame discarded
    set_frame(3, 8'hFF);
    req = 4'b1000;
    repeat (6) @(negedge clk);
    check("t5.busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5.busy", busy, 0);
    check("t5.det_rst_n", det_rst_n, 0);
    check("t5.det_in", det_in, 0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || (ack != '0)) saw = 1'b1;
    end
    check("t5.no_done", saw, 0);
    set_frame(0, 8'h49);
    req = 4'b1001;
    reset_n = 1'b1;
    serve("t5", 0, 2, 10);
    req = '0;
    @(negedge clk);

    // frame change and req drop during SHIFT do not affect the frame in flight
    set_frame(1, 8'h49);
    req = 4'b0010;
    repeat (4) @(negedge clk);
    set_frame(1, 8'hFF);
    req = '0;
    serve("t6", 1, 2, 6);
    @(negedge clk);
    check("t6.ack_clear", ack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
